// File: rtl/calc2_pkg.sv
// calc2_pkg: shared types, width and the execution-unit function for calc2.
package calc2_pkg;
   localparam int DATA_W = 32;
   typedef enum logic [3:0] {IDLE = 4'd0, ADD = 4'd1, SUB = 4'd2, SHL = 4'd5, SHR = 4'd6} cmd_e;
   typedef enum logic [1:0] {NONE = 2'd0, OK = 2'd1, ERR = 2'd2} resp_e;
   typedef struct packed {
      logic [3:0]        cmd;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [1:0]        tag;
      logic [1:0]        port;
   } req_t;
   typedef struct packed {
      resp_e             resp;
      logic [DATA_W-1:0] data;
   } res_t;
   function automatic logic is_shift(logic [3:0] c);
      return c == SHL || c == SHR;
   endfunction
   // Invalid commands fall to default so they come back as ERR with zero data.
   function automatic res_t exec(req_t r);
      logic [DATA_W:0] w_sum;
      w_sum = {1'b0, r.op1} + {1'b0, r.op2};
      case (r.cmd)
         ADD:     exec = w_sum[DATA_W] ? res_t'{ERR, '0} : res_t'{OK, w_sum[DATA_W-1:0]};
         SUB:     exec = r.op2 > r.op1 ? res_t'{ERR, '0} : res_t'{OK, r.op1 - r.op2};
         SHL:     exec = res_t'{OK, r.op1 << r.op2[4:0]};
         SHR:     exec = res_t'{OK, r.op1 >> r.op2[4:0]};
         default: exec = res_t'{ERR, '0};
      endcase
   endfunction
endpackage

// File: rtl/calc2_port_if.sv
// calc2_port_if: two-cycle request capture, 4-entry tag-checked queue and
// registered response output for one calc2 port.
module calc2_port_if
   import calc2_pkg::*;
#(
   parameter logic [1:0] PORT = 2'd0
) (
   input  logic              c_clk,
   input  logic              reset,
   input  logic [3:0]        i_cmd,
   input  logic [DATA_W-1:0] i_data,
   input  logic [1:0]        i_tag,
   output logic              o_as_vld,
   output req_t              o_as_req,
   output logic              o_sh_vld,
   output req_t              o_sh_req,
   input  logic              i_as_gnt,
   input  logic              i_sh_gnt,
   input  logic              i_cpl_vld,
   input  res_t              i_cpl_res,
   input  logic [1:0]        i_cpl_tag,
   output logic [1:0]        o_resp,
   output logic [DATA_W-1:0] o_data,
   output logic [1:0]        o_tag
);
   logic              r_pend;
   logic [3:0]        r_cmd;
   logic [DATA_W-1:0] r_op1;
   logic [1:0]        r_tag;
   req_t              r_q [4];
   logic [2:0]        r_cnt;
   logic [3:0]        r_busy;
   req_t              w_qn [4];
   logic [2:0]        w_cnt_n;
   logic [1:0]        w_as_idx, w_sh_idx, w_rm_idx;
   logic              w_rm, w_push;
   // Queue is kept oldest-first at index 0; scanning downward leaves the oldest match.
   always_comb begin
      o_as_vld = 1'b0;
      o_sh_vld = 1'b0;
      w_as_idx = '0;
      w_sh_idx = '0;
      for (int i = 3; i >= 0; i--) begin
         if (3'(i) < r_cnt && !is_shift(r_q[i].cmd)) begin
            o_as_vld = 1'b1;
            w_as_idx = 2'(i);
         end
         if (3'(i) < r_cnt && is_shift(r_q[i].cmd)) begin
            o_sh_vld = 1'b1;
            w_sh_idx = 2'(i);
         end
      end
   end
   assign o_as_req = r_q[w_as_idx];
   assign o_sh_req = r_q[w_sh_idx];
   assign w_rm     = i_as_gnt | i_sh_gnt;
   assign w_rm_idx = i_as_gnt ? w_as_idx : w_sh_idx;
   // A tag completing on this edge is free again; outstanding tags cap the queue at 4.
   assign w_push   = r_pend && !(r_busy[r_tag] && !(i_cpl_vld && i_cpl_tag == r_tag));
   always_comb begin
      w_cnt_n = r_cnt - 3'(w_rm);
      for (int i = 0; i < 4; i++)
         w_qn[i] = (w_rm && 2'(i) >= w_rm_idx && i < 3) ? r_q[(i + 1) % 4] : r_q[i];
      if (w_push)
         w_qn[w_cnt_n[1:0]] = '{cmd: r_cmd, op1: r_op1, op2: i_data, tag: r_tag, port: PORT};
   end
   always_ff @(posedge c_clk) begin
      r_q <= w_qn;
      if (!r_pend) begin
         r_cmd <= i_cmd;
         r_op1 <= i_data;
         r_tag <= i_tag;
      end
   end
   always_ff @(posedge c_clk) begin
      if (reset) begin
         r_pend <= 1'b0;
         r_cnt  <= '0;
         r_busy <= '0;
         o_resp <= '0;
         o_data <= '0;
         o_tag  <= '0;
      end else begin
         r_pend <= !r_pend && i_cmd != 4'd0;
         r_cnt  <= w_cnt_n + 3'(w_push);
         r_busy <= (r_busy & ~(i_cpl_vld ? 4'b1 << i_cpl_tag : 4'b0)) | (w_push ? 4'b1 << r_tag : 4'b0);
         o_resp <= i_cpl_vld ? i_cpl_res.resp : NONE;
         o_data <= i_cpl_vld ? i_cpl_res.data : '0;
         o_tag  <= i_cpl_vld ? i_cpl_tag : 2'd0;
      end
   end
endmodule

// File: rtl/calc2.sv
// calc2: four-port calculator with a shared add/sub unit and a shared shift unit,
// each a 2-stage pipeline fed by fixed-priority dispatch.
module calc2 #(
   parameter int DATA_W = 32
) (
   input  logic              c_clk,
   input  logic              reset,
   input  logic [3:0]        req1_cmd_in,
   input  logic [3:0]        req2_cmd_in,
   input  logic [3:0]        req3_cmd_in,
   input  logic [3:0]        req4_cmd_in,
   input  logic [DATA_W-1:0] req1_data_in,
   input  logic [DATA_W-1:0] req2_data_in,
   input  logic [DATA_W-1:0] req3_data_in,
   input  logic [DATA_W-1:0] req4_data_in,
   input  logic [1:0]        req1_tag_in,
   input  logic [1:0]        req2_tag_in,
   input  logic [1:0]        req3_tag_in,
   input  logic [1:0]        req4_tag_in,
   output logic [1:0]        out_resp1,
   output logic [1:0]        out_resp2,
   output logic [1:0]        out_resp3,
   output logic [1:0]        out_resp4,
   output logic [DATA_W-1:0] out_data1,
   output logic [DATA_W-1:0] out_data2,
   output logic [DATA_W-1:0] out_data3,
   output logic [DATA_W-1:0] out_data4,
   output logic [1:0]        out_tag1,
   output logic [1:0]        out_tag2,
   output logic [1:0]        out_tag3,
   output logic [1:0]        out_tag4
);
   import calc2_pkg::*;
   logic [3:0]        w_cmd [4];
   logic [DATA_W-1:0] w_dat [4];
   logic [1:0]        w_tag [4];
   logic [1:0]        w_resp [4];
   logic [DATA_W-1:0] w_odat [4];
   logic [1:0]        w_otag [4];
   logic [3:0]        w_as_vld, w_sh_vld, w_as_gnt, w_sh_gnt;
   req_t              w_as_req [4];
   req_t              w_sh_req [4];
   logic [1:0]        w_as_p, w_sh_p;
   logic [1:0]        r_s1_v, r_s2_v;
   req_t              r_s1 [2];
   res_t              r_s2_res [2];
   logic [1:0]        r_s2_tag [2];
   logic [1:0]        r_s2_port [2];
   assign w_cmd = '{req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in};
   assign w_dat = '{req1_data_in, req2_data_in, req3_data_in, req4_data_in};
   assign w_tag = '{req1_tag_in, req2_tag_in, req3_tag_in, req4_tag_in};
   assign out_resp1 = w_resp[0];
   assign out_resp2 = w_resp[1];
   assign out_resp3 = w_resp[2];
   assign out_resp4 = w_resp[3];
   assign out_data1 = w_odat[0];
   assign out_data2 = w_odat[1];
   assign out_data3 = w_odat[2];
   assign out_data4 = w_odat[3];
   assign out_tag1  = w_otag[0];
   assign out_tag2  = w_otag[1];
   assign out_tag3  = w_otag[2];
   assign out_tag4  = w_otag[3];
   // Shift grant skips the port that already won add/sub: one dispatch per port per cycle.
   always_comb begin
      w_as_p = '0;
      w_sh_p = '0;
      for (int p = 3; p >= 0; p--)
         if (w_as_vld[p]) w_as_p = 2'(p);
      w_as_gnt = (|w_as_vld) ? 4'b1 << w_as_p : 4'b0;
      for (int p = 3; p >= 0; p--)
         if (w_sh_vld[p] && !w_as_gnt[p]) w_sh_p = 2'(p);
      w_sh_gnt = (|(w_sh_vld & ~w_as_gnt)) ? 4'b1 << w_sh_p : 4'b0;
   end
   always_ff @(posedge c_clk) begin
      if (reset) begin
         r_s1_v <= '0;
         r_s2_v <= '0;
      end else begin
         r_s1_v <= {|w_sh_gnt, |w_as_gnt};
         r_s2_v <= r_s1_v;
      end
   end
   always_ff @(posedge c_clk) begin
      r_s1[0] <= w_as_req[w_as_p];
      r_s1[1] <= w_sh_req[w_sh_p];
      for (int u = 0; u < 2; u++) begin
         r_s2_res[u]  <= exec(r_s1[u]);
         r_s2_tag[u]  <= r_s1[u].tag;
         r_s2_port[u] <= r_s1[u].port;
      end
   end
   for (genvar p = 0; p < 4; p++) begin : g_port
      logic w_sel0, w_sel1;
      assign w_sel0 = r_s2_v[0] && r_s2_port[0] == 2'(p);
      assign w_sel1 = r_s2_v[1] && r_s2_port[1] == 2'(p);
      calc2_port_if #(.PORT(2'(p))) u_port (
         .c_clk     (c_clk),
         .reset     (reset),
         .i_cmd     (w_cmd[p]),
         .i_data    (w_dat[p]),
         .i_tag     (w_tag[p]),
         .o_as_vld  (w_as_vld[p]),
         .o_as_req  (w_as_req[p]),
         .o_sh_vld  (w_sh_vld[p]),
         .o_sh_req  (w_sh_req[p]),
         .i_as_gnt  (w_as_gnt[p]),
         .i_sh_gnt  (w_sh_gnt[p]),
         .i_cpl_vld (w_sel0 || w_sel1),
         .i_cpl_res (w_sel0 ? r_s2_res[0] : r_s2_res[1]),
         .i_cpl_tag (w_sel0 ? r_s2_tag[0] : r_s2_tag[1]),
         .o_resp    (w_resp[p]),
         .o_data    (w_odat[p]),
         .o_tag     (w_otag[p])
      );
   end
endmodule

// File: tb/tb_calc2.sv
// tb_calc2: directed scoreboard bench for calc2; expectations carry port, tag,
// response, data and the cycle on which the response must appear.
module tb_calc2;
   logic        c_clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  cmd [4];
   logic [31:0] dat [4];
   logic [1:0]  tg [4];
   logic [1:0]  o_resp [4];
   logic [31:0] o_data [4];
   logic [1:0]  o_tag [4];
   typedef struct {
      int          port;
      logic [1:0]  resp;
      logic [31:0] data;
      logic [1:0]  tag;
      int          cyc;
   } exp_t;
   exp_t sb[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   calc2 dut (
      .c_clk(c_clk), .reset(reset),
      .req1_cmd_in(cmd[0]), .req2_cmd_in(cmd[1]), .req3_cmd_in(cmd[2]), .req4_cmd_in(cmd[3]),
      .req1_data_in(dat[0]), .req2_data_in(dat[1]), .req3_data_in(dat[2]), .req4_data_in(dat[3]),
      .req1_tag_in(tg[0]), .req2_tag_in(tg[1]), .req3_tag_in(tg[2]), .req4_tag_in(tg[3]),
      .out_resp1(o_resp[0]), .out_resp2(o_resp[1]), .out_resp3(o_resp[2]), .out_resp4(o_resp[3]),
      .out_data1(o_data[0]), .out_data2(o_data[1]), .out_data3(o_data[2]), .out_data4(o_data[3]),
      .out_tag1(o_tag[0]), .out_tag2(o_tag[1]), .out_tag3(o_tag[2]), .out_tag4(o_tag[3])
   );
   always #5 c_clk = ~c_clk;
   always @(posedge c_clk) cyc <= cyc + 1;
   task automatic step(input int n = 1);
      repeat (n) @(negedge c_clk);
   endtask
   task automatic start(input int p, input logic [3:0] c, input logic [31:0] a, input logic [1:0] t);
      cmd[p] = c;
      dat[p] = a;
      tg[p]  = t;
   endtask
   // Cycle B drives junk cmd/tag, which the DUT must ignore.
   task automatic second(input int p, input logic [31:0] b);
      cmd[p] = 4'd2;
      tg[p]  = ~tg[p];
      dat[p] = b;
   endtask
   task automatic op(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [1:0] t);
      start(p, c, a, t);
      step();
      second(p, b);
      step();
      cmd[p] = 4'd0;
   endtask
   task automatic expect_rsp(input int p, input logic [1:0] r, input logic [31:0] d, input logic [1:0] t, input int lat);
      sb.push_back(exp_t'{p, r, d, t, cyc + lat});
   endtask
   always @(negedge c_clk) begin
      if (!reset) begin
         for (int p = 0; p < 4; p++) begin
            if (o_resp[p] == 2'd0) begin
               total++;
               assert (o_data[p] === 32'd0 && o_tag[p] === 2'd0) else begin
                  bad++;
                  $error("FAIL idle_p%0d data=%h tag=%0d want data=0 tag=0", p + 1, o_data[p], o_tag[p]);
               end
            end else begin
               int k;
               k = -1;
               foreach (sb[i])
                  if (k < 0 && sb[i].port == p && sb[i].tag == o_tag[p]) k = i;
               total++;
               assert (k >= 0) else begin
                  bad++;
                  $error("FAIL unexpected_p%0d resp=%0d data=%h tag=%0d cyc=%0d want no response", p + 1, o_resp[p], o_data[p], o_tag[p], cyc);
               end
               if (k >= 0) begin
                  total++;
                  assert ({o_resp[p], o_data[p], cyc} === {sb[k].resp, sb[k].data, sb[k].cyc}) else begin
                     bad++;
                     $error("FAIL rsp_p%0d_tag%0d got resp=%0d data=%h cyc=%0d want resp=%0d data=%h cyc=%0d",
                            p + 1, o_tag[p], o_resp[p], o_data[p], cyc, sb[k].resp, sb[k].data, sb[k].cyc);
                  end
                  sb.delete(k);
               end
            end
         end
      end
   end
   initial begin
      for (int p = 0; p < 4; p++) begin
         cmd[p] = 4'd0;
         dat[p] = 32'd0;
         tg[p]  = 2'd0;
      end
      step(3);
      for (int p = 0; p < 4; p++) begin
         total++;
         assert (o_resp[p] === 2'd0 && o_data[p] === 32'd0 && o_tag[p] === 2'd0) else begin
            bad++;
            $error("FAIL reset_p%0d resp=%0d data=%h tag=%0d want all 0", p + 1, o_resp[p], o_data[p], o_tag[p]);
         end
      end
      reset = 1'b0;
      op(0, 4'd1, 32'h30, 32'h20, 2'd1);
      expect_rsp(0, 2'd1, 32'h50, 2'd1, 3);
      step(6);
      op(1, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd0);
      expect_rsp(1, 2'd2, 32'h0, 2'd0, 3);
      op(1, 4'd2, 32'h10, 32'h20, 2'd2);
      expect_rsp(1, 2'd2, 32'h0, 2'd2, 3);
      op(1, 4'd2, 32'h50, 32'h20, 2'd3);
      expect_rsp(1, 2'd1, 32'h30, 2'd3, 3);
      op(1, 4'd1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd1);
      expect_rsp(1, 2'd1, 32'hFFFF_FFFF, 2'd1, 3);
      step(6);
      op(2, 4'd5, 32'h1, 32'd31, 2'd0);
      expect_rsp(2, 2'd1, 32'h8000_0000, 2'd0, 3);
      op(2, 4'd6, 32'h8000_0000, 32'h21, 2'd1);
      expect_rsp(2, 2'd1, 32'h4000_0000, 2'd1, 3);
      op(2, 4'd5, 32'hF, 32'hFFFF_FFE4, 2'd2);
      expect_rsp(2, 2'd1, 32'hF0, 2'd2, 3);
      step(6);
      for (int p = 0; p < 4; p++) start(p, 4'd1, 32'(p + 1), 2'd2);
      step();
      for (int p = 0; p < 4; p++) second(p, 32'(16 * (p + 1)));
      step();
      for (int p = 0; p < 4; p++) begin
         cmd[p] = 4'd0;
         expect_rsp(p, 2'd1, 32'(17 * (p + 1)), 2'd2, 3 + p);
      end
      step(8);
      start(0, 4'd1, 32'd5, 2'd1);
      start(1, 4'd5, 32'd3, 2'd1);
      start(2, 4'd1, 32'd9, 2'd1);
      step();
      second(0, 32'd6);
      second(1, 32'd2);
      second(2, 32'd1);
      step();
      for (int p = 0; p < 3; p++) cmd[p] = 4'd0;
      expect_rsp(0, 2'd1, 32'd11, 2'd1, 3);
      expect_rsp(1, 2'd1, 32'd12, 2'd1, 3);
      expect_rsp(2, 2'd1, 32'd10, 2'd1, 4);
      step(8);
      op(3, 4'd4, 32'h1234, 32'h5678, 2'd3);
      expect_rsp(3, 2'd2, 32'h0, 2'd3, 3);
      op(3, 4'd1, 32'd1, 32'd1, 2'd3);
      op(3, 4'd15, 32'd1, 32'd1, 2'd0);
      expect_rsp(3, 2'd2, 32'h0, 2'd0, 3);
      step(6);
      op(3, 4'd1, 32'd5, 32'd6, 2'd3);
      expect_rsp(3, 2'd1, 32'd11, 2'd3, 3);
      step(6);
      start(0, 4'd1, 32'd1, 2'd0);
      step();
      reset = 1'b1;
      second(0, 32'd2);
      step();
      total++;
      assert (o_resp[0] === 2'd0 && o_data[0] === 32'd0 && o_tag[0] === 2'd0) else begin
         bad++;
         $error("FAIL midreset_out resp=%0d data=%h tag=%0d want all 0", o_resp[0], o_data[0], o_tag[0]);
      end
      reset = 1'b0;
      cmd[0] = 4'd0;
      step(12);
      op(0, 4'd1, 32'd7, 32'd8, 2'd0);
      expect_rsp(0, 2'd1, 32'd15, 2'd0, 3);
      step(10);
      total++;
      assert (sb.size() === 0) else begin
         bad++;
         $error("FAIL missing_responses got %0d outstanding want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
